ctrl_sequencer: RTL
===================

// Module: ctrl_sequencer
// PURPOSE
//  Moore control sequencer for the basic processor; sits directly upstream of the RAM and datapath.
//  Drives RAM strobes (load_MAR, load_MDR, MDR_bus, CS, R_NW), register loads and bus enables.
//  Decodes the opcode field of the IR to step fetch/execute micro-cycles.
//  Exactly one instruction is in flight; no pipelining.
// PARAMETERS
//  WORD_W  8  system bus word width (informational, keeps parity with datapath/RAM)
//  OP_W    3  opcode field width; op port width
// PORTS
//  clock     in   1     single system clock, all state on posedge
//  reset     in   1     synchronous, active-high reset
//  run       in   1     start/continue enable, sampled in IDLE and FETCH0
//  op        in   OP_W  opcode field of IR (IR[WORD_W-1 -: OP_W])
//  z_flag    in   1     ACC==0 flag from datapath
//  PC_bus    out  1     PC drives sysbus
//  IR_bus    out  1     IR address field drives sysbus
//  ACC_bus   out  1     ACC drives sysbus
//  MDR_bus   out  1     RAM MDR drives sysbus
//  load_MAR  out  1     RAM MAR <= sysbus
//  load_MDR  out  1     RAM MDR <= sysbus
//  CS        out  1     RAM access strobe
//  R_NW      out  1     1=read mem->MDR, 0=write MDR->mem
//  load_IR   out  1     IR <= sysbus
//  load_ACC  out  1     ACC <= ALU result
//  load_PC   out  1     PC <= sysbus
//  INC_PC    out  1     PC <= PC+1
//  alu_op    out  2     ALU_PASS/ALU_ADD/ALU_SUB
//  instr_done out 1     one-cycle pulse on last micro-cycle of each instruction
//  halted    out  1     high while in HALTED
// BEHAVIOUR
//  Reset: state<=IDLE on any posedge with reset=1, including mid-instruction; outputs
//   decode from state only, so in IDLE all outputs 0 except R_NW=1, alu_op=ALU_PASS.
//  Defaults in every state: all strobes 0, R_NW=1, alu_op=ALU_PASS, unless listed.
//  IDLE:   run ? FETCH0 : IDLE.
//  FETCH0: PC_bus,load_MAR,INC_PC. run=0 -> IDLE (fetch aborted, PC already advanced).
//          run=1 -> FETCH1.
//  FETCH1: CS (read). -> FETCH2.
//  FETCH2: MDR_bus,load_IR. -> DECODE.
//  DECODE: IR_bus,load_MAR. Branch on op: LOAD/ADD/SUB->MREAD; STORE->ST1; BNE->BR;
//          HALT->HALTED; undefined opcode->FETCH0 with instr_done=1 (NOP, 4 cycles).
//  MREAD:  CS (read). -> EXEC.
//  EXEC:   MDR_bus,load_ACC,instr_done; alu_op=PASS(LOAD)/ADD/SUB per latched op. -> FETCH0.
//  ST1:    ACC_bus,load_MDR. -> ST2.
//  ST2:    CS, R_NW=0, instr_done. -> FETCH0.
//  BR:     if z_flag=0: IR_bus,load_PC; always instr_done. -> FETCH0. z_flag sampled in BR.
//  HALTED: halted=1; stays until reset; run ignored.
//  Latency incl. fetch: LOAD/ADD/SUB/STORE 6 cycles, BNE 5, NOP 4.
//  op is sampled in DECODE and EXEC; IR must be stable from FETCH2 onward.
//  Invariant: at most one of PC_bus/IR_bus/ACC_bus/MDR_bus high in any cycle.
//  Invariant: load_MAR/load_MDR/CS mutually exclusive (RAM priority never exercised).
//  Unreachable state encodings -> IDLE next cycle.
// STRUCTURE
//  Package cpu_pkg: opcode_t (LOAD=0,STORE=1,ADD=2,SUB=3,BNE=4,HALT=7; 5,6 undefined),
//   alu_op_t (ALU_PASS=0,ALU_ADD=1,ALU_SUB=2), seq_state_t enum.
//  Single module: state register always_ff + next-state always_comb + output always_comb;
//   no sub-module.
// TESTING
//  reset=1 during ST1, then released with run=0 -> IDLE, all strobes 0, R_NW=1, halted=0.
//  run=1, op=LOAD -> strobe trace F0..EXEC over 6 cycles, alu_op=PASS in EXEC,
//   one instr_done pulse.
//  op=STORE -> ST1 ACC_bus+load_MDR, ST2 CS=1,R_NW=0; no other cycle has R_NW=0.
//  op=BNE, z_flag=0 -> load_PC=1 with IR_bus in cycle 5; z_flag=1 -> load_PC stays 0, 5 cycles.
//  op=SUB, then op=5 (undefined) -> EXEC alu_op=SUB; NOP returns to FETCH0 after 4 cycles.
//  op=HALT -> halted=1 from cycle 5, held 20 cycles with run=1; reset -> IDLE.
//  All runs: SVA checks on bus and RAM-strobe exclusivity every cycle.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared encodings for the basic processor: opcodes, ALU operations and sequencer states.
package cpu_pkg;

  typedef enum logic [2:0] {
    LOAD  = 3'd0,
    STORE = 3'd1,
    ADD   = 3'd2,
    SUB   = 3'd3,
    BNE   = 3'd4,
    HALT  = 3'd7
  } opcode_t;

  typedef enum logic [1:0] {
    ALU_PASS = 2'd0,
    ALU_ADD  = 2'd1,
    ALU_SUB  = 2'd2
  } alu_op_t;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    FETCH0 = 4'd1,
    FETCH1 = 4'd2,
    FETCH2 = 4'd3,
    DECODE = 4'd4,
    MREAD  = 4'd5,
    EXEC   = 4'd6,
    ST1    = 4'd7,
    ST2    = 4'd8,
    BR     = 4'd9,
    HALTED = 4'd10
  } seq_state_t;

  // Opcodes 5 and 6 are unassigned and execute as a 4-cycle NOP.
  function automatic logic op_defined(logic [2:0] o);
    return (o == LOAD) || (o == STORE) || (o == ADD) || (o == SUB) ||
           (o == BNE) || (o == HALT);
  endfunction

endpackage

// File: rtl/ctrl_sequencer.sv
// Moore fetch/execute control sequencer driving RAM strobes, register loads and bus enables.
// One instruction in flight; outputs decode from the state register (plus op/z_flag where branching).
module ctrl_sequencer
  import cpu_pkg::*;
#(
  parameter int WORD_W = 8,
  parameter int OP_W   = 3
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            run,
  input  logic [OP_W-1:0] op,
  input  logic            z_flag,
  output logic            PC_bus,
  output logic            IR_bus,
  output logic            ACC_bus,
  output logic            MDR_bus,
  output logic            load_MAR,
  output logic            load_MDR,
  output logic            CS,
  output logic            R_NW,
  output logic            load_IR,
  output logic            load_ACC,
  output logic            load_PC,
  output logic            INC_PC,
  output logic [1:0]      alu_op,
  output logic            instr_done,
  output logic            halted
);

  // The opcode field is carved out of the top of an IR word, so it can never be wider than one.
  if (OP_W > WORD_W) begin : g_op_wider_than_word
  end

  seq_state_t state;
  seq_state_t state_nxt;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE:   state_nxt = run ? FETCH0 : IDLE;
      FETCH0: state_nxt = run ? FETCH1 : IDLE;
      FETCH1: state_nxt = FETCH2;
      FETCH2: state_nxt = DECODE;
      DECODE: begin
        case (op)
          LOAD, ADD, SUB: state_nxt = MREAD;
          STORE:          state_nxt = ST1;
          BNE:            state_nxt = BR;
          HALT:           state_nxt = HALTED;
          default:        state_nxt = FETCH0;
        endcase
      end
      MREAD:  state_nxt = EXEC;
      EXEC:   state_nxt = FETCH0;
      ST1:    state_nxt = ST2;
      ST2:    state_nxt = FETCH0;
      BR:     state_nxt = FETCH0;
      HALTED: state_nxt = HALTED;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    PC_bus     = 1'b0;
    IR_bus     = 1'b0;
    ACC_bus    = 1'b0;
    MDR_bus    = 1'b0;
    load_MAR   = 1'b0;
    load_MDR   = 1'b0;
    CS         = 1'b0;
    R_NW       = 1'b1;
    load_IR    = 1'b0;
    load_ACC   = 1'b0;
    load_PC    = 1'b0;
    INC_PC     = 1'b0;
    alu_op     = ALU_PASS;
    instr_done = 1'b0;
    halted     = 1'b0;
    case (state)
      FETCH0: begin
        PC_bus   = 1'b1;
        load_MAR = 1'b1;
        INC_PC   = 1'b1;
      end
      FETCH1: CS = 1'b1;
      FETCH2: begin
        MDR_bus = 1'b1;
        load_IR = 1'b1;
      end
      DECODE: begin
        IR_bus     = 1'b1;
        load_MAR   = 1'b1;
        instr_done = !op_defined(op);
      end
      MREAD: CS = 1'b1;
      EXEC: begin
        MDR_bus    = 1'b1;
        load_ACC   = 1'b1;
        instr_done = 1'b1;
        case (op)
          ADD:     alu_op = ALU_ADD;
          SUB:     alu_op = ALU_SUB;
          default: alu_op = ALU_PASS;
        endcase
      end
      ST1: begin
        ACC_bus  = 1'b1;
        load_MDR = 1'b1;
      end
      ST2: begin
        CS         = 1'b1;
        R_NW       = 1'b0;
        instr_done = 1'b1;
      end
      // A taken branch (ACC non-zero) reloads PC from the IR address field.
      BR: begin
        IR_bus     = !z_flag;
        load_PC    = !z_flag;
        instr_done = 1'b1;
      end
      HALTED: halted = 1'b1;
      default: ;
    endcase
  end

endmodule
